// File: rtl/vrf_read_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vrf_read_pipe_pkg                                                |
// | Brief   : Shared types, arbitration modes and width helpers for the VRF    |
// |           read port front end.                                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package vrf_read_pipe_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int DEF_VS_WIDTH     = 5;
  localparam int DEF_OFFSET_WIDTH = 3;
  localparam int DEF_SOURCE_WIDTH = 2;
  localparam int DEF_INDEX_WIDTH  = 3;

  // Request layout at the default field widths.
  typedef struct packed {
    logic [DEF_VS_WIDTH-1:0]     vs;
    logic [DEF_OFFSET_WIDTH-1:0] offset;
    logic [DEF_SOURCE_WIDTH-1:0] source;
    logic [DEF_INDEX_WIDTH-1:0]  index;
  } vrf_read_req_t;

  // Counter wide enough to hold 0..depth inclusive.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vrf_read_data_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vrf_read_data_fifo                                               |
// | Brief   : Per-channel result FIFO, head visible combinationally, no bypass.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module vrf_read_data_fifo
  import vrf_read_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = idWidth(DEPTH);
  localparam int CNT_W = cntWidth(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(DEPTH));
  assign head     = r_mem[r_rdPtr];
  assign w_doPop  = pop & ~empty;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign w_doPush = push & (~full | w_doPop);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPop)
        r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
      if (w_doPush)
        r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
      if (w_doPush && !w_doPop)
        r_count <= r_count + 1'b1;
      else if (!w_doPush && w_doPop)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_doPush)
      r_mem[r_wrPtr] <= pushData;
  end

  a_noOverflow : assert property (@(posedge clock) disable iff (!rst_n)
                                  (push && full) |-> pop);

endmodule
`default_nettype wire

// File: rtl/vrf_read_pipe_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vrf_read_pipe_multi                                              |
// | Brief   : N-channel credit-admitted VRF read arbiter with fixed-latency    |
// |           tag pipeline steering read data into per-channel FIFOs.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module vrf_read_pipe_multi
  import vrf_read_pipe_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int ARB_MODE     = ARB_RR,
  parameter int VS_WIDTH     = 5,
  parameter int OFFSET_WIDTH = 3,
  parameter int SOURCE_WIDTH = 2,
  parameter int INDEX_WIDTH  = 3
) (
  input  logic                                 clock,
  input  logic                                 rst_n,
  input  logic [NUM_CHANNELS-1:0]              req_valid,
  output logic [NUM_CHANNELS-1:0]              req_ready,
  input  logic [NUM_CHANNELS*VS_WIDTH-1:0]     req_vs,
  input  logic [NUM_CHANNELS*OFFSET_WIDTH-1:0] req_offset,
  input  logic [NUM_CHANNELS*SOURCE_WIDTH-1:0] req_source,
  input  logic [NUM_CHANNELS*INDEX_WIDTH-1:0]  req_index,
  output logic                                 vrf_req_valid,
  input  logic                                 vrf_req_ready,
  output logic [VS_WIDTH-1:0]                  vrf_req_vs,
  output logic [OFFSET_WIDTH-1:0]              vrf_req_offset,
  output logic [SOURCE_WIDTH-1:0]              vrf_req_source,
  output logic [INDEX_WIDTH-1:0]               vrf_req_index,
  input  logic [DATA_WIDTH-1:0]                vrf_rdata,
  output logic [NUM_CHANNELS-1:0]              deq_valid,
  input  logic [NUM_CHANNELS-1:0]              deq_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   deq_data
);

  localparam int ID_W  = idWidth(NUM_CHANNELS);
  localparam int CNT_W = cntWidth(FIFO_DEPTH);
  localparam logic [ID_W-1:0] c_lastReset = ID_W'(NUM_CHANNELS - 1);

  logic [CNT_W-1:0]        r_cnt [NUM_CHANNELS];
  logic [ID_W-1:0]         r_last;
  logic                    r_tagValid [READ_LATENCY];
  logic [ID_W-1:0]         r_tagId [READ_LATENCY];
  logic [NUM_CHANNELS-1:0] w_elig;
  logic [NUM_CHANNELS-1:0] w_grant;
  logic [NUM_CHANNELS-1:0] w_pop;
  logic [NUM_CHANNELS-1:0] w_push;
  logic [NUM_CHANNELS-1:0] w_empty;
  logic [NUM_CHANNELS-1:0] w_full;
  logic [ID_W-1:0]         w_grantIdx;
  logic                    w_fire;

  // Credit check: occupancy plus in-flight reads must leave room in the FIFO.
  always_comb begin
    w_elig = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      w_elig[c] = req_valid[c] & (r_cnt[c] < CNT_W'(FIFO_DEPTH));
  end

  always_comb begin : arbiter
    int   idx;
    logic found;
    w_grant    = '0;
    w_grantIdx = '0;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ARB_MODE == ARB_FIXED)
        idx = i;
      else
        idx = (int'(r_last) + 1 + i) % NUM_CHANNELS;
      if (!found && w_elig[idx]) begin
        found        = 1'b1;
        w_grant[idx] = 1'b1;
        w_grantIdx   = ID_W'(idx);
      end
    end
  end

  always_comb begin : fieldMux
    vrf_req_vs     = '0;
    vrf_req_offset = '0;
    vrf_req_source = '0;
    vrf_req_index  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_grant[c]) begin
        vrf_req_vs     = req_vs[c*VS_WIDTH +: VS_WIDTH];
        vrf_req_offset = req_offset[c*OFFSET_WIDTH +: OFFSET_WIDTH];
        vrf_req_source = req_source[c*SOURCE_WIDTH +: SOURCE_WIDTH];
        vrf_req_index  = req_index[c*INDEX_WIDTH +: INDEX_WIDTH];
      end
    end
  end

  assign vrf_req_valid = rst_n & (|w_elig);
  assign w_fire        = vrf_req_valid & vrf_req_ready;
  assign req_ready     = w_grant & {NUM_CHANNELS{w_fire}};
  assign w_pop         = deq_valid & deq_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_lastReset;
      for (int c = 0; c < NUM_CHANNELS; c++)
        r_cnt[c] <= '0;
    end else begin
      if (w_fire)
        r_last <= w_grantIdx;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (req_ready[c] && !w_pop[c])
          r_cnt[c] <= r_cnt[c] + 1'b1;
        else if (!req_ready[c] && w_pop[c])
          r_cnt[c] <= r_cnt[c] - 1'b1;
      end
    end
  end

  // Reset drops every tag, so data still returning for discarded reads is ignored.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_tagValid[s] <= 1'b0;
        r_tagId[s]    <= '0;
      end
    end else begin
      r_tagValid[0] <= w_fire;
      r_tagId[0]    <= w_grantIdx;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_tagValid[s] <= r_tagValid[s-1];
        r_tagId[s]    <= r_tagId[s-1];
      end
    end
  end

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      assign w_push[c]    = r_tagValid[READ_LATENCY-1] &&
                            (r_tagId[READ_LATENCY-1] == ID_W'(c));
      assign deq_valid[c] = ~w_empty[c];

      vrf_read_data_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
      ) u_fifo (
        .clock    (clock),
        .rst_n    (rst_n),
        .push     (w_push[c]),
        .pushData (vrf_rdata),
        .pop      (deq_ready[c]),
        .empty    (w_empty[c]),
        .full     (w_full[c]),
        .head     (deq_data[c*DATA_WIDTH +: DATA_WIDTH])
      );

      a_creditCoversFull : assert property (@(posedge clock) disable iff (!rst_n)
                                            w_full[c] |-> (r_cnt[c] == CNT_W'(FIFO_DEPTH)));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vrf_read_pipe_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vrf_read_pipe_multi                                           |
// | Brief   : Scenario tasks plus randomized traffic against a queue model.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_vrf_read_pipe_multi;

  localparam int NCH = 2, DW = 32, LAT = 2, DEPTH = 4;
  localparam int VSW = 5, OFW = 3, SRW = 2, IXW = 3;

  logic             clock = 1'b0;
  logic             rst_n = 1'b1;
  logic [NCH-1:0]   req_valid, req_ready, fx_req_ready;
  logic [NCH*VSW-1:0] req_vs;
  logic [NCH*OFW-1:0] req_offset;
  logic [NCH*SRW-1:0] req_source;
  logic [NCH*IXW-1:0] req_index;
  logic             vrf_req_valid, fx_vrf_req_valid, vrf_req_ready;
  logic [VSW-1:0]   vrf_req_vs, fx_vrf_req_vs;
  logic [OFW-1:0]   vrf_req_offset, fx_vrf_req_offset;
  logic [SRW-1:0]   vrf_req_source, fx_vrf_req_source;
  logic [IXW-1:0]   vrf_req_index, fx_vrf_req_index;
  logic [DW-1:0]    vrf_rdata;
  logic [NCH-1:0]   deq_valid, fx_deq_valid, deq_ready;
  logic [NCH*DW-1:0] deq_data, fx_deq_data;

  always #5 clock = ~clock;

  vrf_read_pipe_multi #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .READ_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH), .ARB_MODE(0)) dut (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vs(req_vs), .req_offset(req_offset), .req_source(req_source), .req_index(req_index),
    .vrf_req_valid(vrf_req_valid), .vrf_req_ready(vrf_req_ready),
    .vrf_req_vs(vrf_req_vs), .vrf_req_offset(vrf_req_offset),
    .vrf_req_source(vrf_req_source), .vrf_req_index(vrf_req_index),
    .vrf_rdata(vrf_rdata), .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data));

  vrf_read_pipe_multi #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .READ_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH), .ARB_MODE(1)) u_fixed (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fx_req_ready),
    .req_vs(req_vs), .req_offset(req_offset), .req_source(req_source), .req_index(req_index),
    .vrf_req_valid(fx_vrf_req_valid), .vrf_req_ready(vrf_req_ready),
    .vrf_req_vs(fx_vrf_req_vs), .vrf_req_offset(fx_vrf_req_offset),
    .vrf_req_source(fx_vrf_req_source), .vrf_req_index(fx_vrf_req_index),
    .vrf_rdata(vrf_rdata), .deq_valid(fx_deq_valid), .deq_ready(deq_ready), .deq_data(fx_deq_data));

  int nCompared = 0;
  int nMismatch = 0;
  int cycleNum  = 0;

  // Reference model: credits, RR pointer, reads in flight, expected FIFO contents.
  typedef struct { int ch; int due; } flight_t;
  int            mCnt [NCH];
  int            mLast;
  flight_t       flights [$];
  logic [DW-1:0] expQ [NCH][$];

  function automatic void modelClear();
    for (int c = 0; c < NCH; c++) begin
      mCnt[c] = 0;
      expQ[c].delete();
    end
    mLast = NCH - 1;
    flights.delete();
  endfunction

  function automatic int expGrant();
    for (int i = 1; i <= NCH; i++) begin
      int c = (mLast + i) % NCH;
      if (req_valid[c] && mCnt[c] < DEPTH) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    int g;
    @(posedge clock);
    if (!rst_n) modelClear();
    else begin
      g = expGrant();
      for (int c = 0; c < NCH; c++)
        if (expQ[c].size() > 0 && deq_ready[c]) begin
          expQ[c].delete(0);
          mCnt[c]--;
        end
      while (flights.size() > 0 && flights[0].due == cycleNum) begin
        expQ[flights[0].ch].push_back(vrf_rdata);
        flights.delete(0);
      end
      if (g >= 0 && vrf_req_ready) begin
        mCnt[g]++;
        mLast = g;
        flights.push_back('{g, cycleNum + LAT});
      end
    end
    cycleNum++;
    #1;
    vrf_rdata = $urandom();
  endtask

  task automatic setIdle();
    req_valid = '0; deq_ready = '1; vrf_req_ready = 1'b1;
    req_vs = '0; req_offset = '0; req_source = '0; req_index = '0;
  endtask

  task automatic applyReset();
    setIdle();
    rst_n = 1'b0;
    modelClear();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    setIdle();
    req_valid = 2'b11;
    req_vs = {5'd12, 5'd7};
    vrf_rdata = '0;
    #1; rst_n = 1'b0; modelClear(); #1;
    nCompared++; if (vrf_req_valid !== 1'b0) begin nMismatch++; $display("FAIL reset_vrf_valid: got %b expected 0", vrf_req_valid); end
    nCompared++; if (req_ready !== 2'b00) begin nMismatch++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    nCompared++; if (deq_valid !== 2'b00) begin nMismatch++; $display("FAIL reset_deq_valid: got %b expected 00", deq_valid); end
    tick(); tick();
    rst_n = 1'b1; #1;
    nCompared++; if (vrf_req_valid !== 1'b1) begin nMismatch++; $display("FAIL post_reset_valid: got %b expected 1", vrf_req_valid); end
    nCompared++; if (req_ready !== 2'b01 || vrf_req_vs !== 5'd7) begin nMismatch++; $display("FAIL post_reset_first_grant: got %b/%0d expected 01/7", req_ready, vrf_req_vs); end
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    applyReset();
    req_valid = 2'b01; req_vs = {5'd9, 5'd3}; req_offset = {3'd1, 3'd5}; #1;
    nCompared++; if (req_ready !== 2'b01 || vrf_req_vs !== 5'd3 || vrf_req_offset !== 3'd5) begin
      nMismatch++; $display("FAIL single_issue: got %b/%0d/%0d expected 01/3/5", req_ready, vrf_req_vs, vrf_req_offset); end
    tick(); req_valid = '0; #1;
    nCompared++; if (deq_valid !== 2'b00) begin nMismatch++; $display("FAIL single_early1: got %b expected 00", deq_valid); end
    tick(); d = 32'hC0DE_0003; vrf_rdata = d; #1;
    nCompared++; if (deq_valid !== 2'b00) begin nMismatch++; $display("FAIL single_early2: got %b expected 00", deq_valid); end
    tick(); #1;
    nCompared++; if (deq_valid !== 2'b01 || deq_data[DW-1:0] !== d) begin
      nMismatch++; $display("FAIL single_data: got %b/%h expected 01/%h", deq_valid, deq_data[DW-1:0], d); end
    tick(); #1;
    nCompared++; if (deq_valid !== 2'b00) begin nMismatch++; $display("FAIL single_drained: got %b expected 00", deq_valid); end
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] e;
    applyReset();
    req_valid = 2'b11; req_vs = {5'd17, 5'd4};
    for (int i = 0; i < 8; i++) begin
      #1;
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      nCompared++; if (req_ready !== e || vrf_req_vs !== ((i % 2 == 0) ? 5'd4 : 5'd17)) begin
        nMismatch++; $display("FAIL rr_alternate[%0d]: got %b/%0d expected %b", i, req_ready, vrf_req_vs, e); end
      tick();
    end
  endtask

  task automatic test_fixed_priority();
    applyReset();
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      nCompared++; if (fx_req_ready !== 2'b01) begin nMismatch++; $display("FAIL fixed_grant[%0d]: got %b expected 01", i, fx_req_ready); end
      tick();
    end
  endtask

  task automatic test_credit_backpressure();
    int grants = 0;
    applyReset();
    deq_ready = 2'b01; req_valid = 2'b10;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req_ready[1]) grants++;
      tick();
    end
    nCompared++; if (grants != DEPTH) begin nMismatch++; $display("FAIL credit_grants: got %0d expected %0d", grants, DEPTH); end
    #1;
    nCompared++; if (req_ready !== 2'b00 || deq_valid !== 2'b10) begin nMismatch++; $display("FAIL credit_exhausted: got %b/%b expected 00/10", req_ready, deq_valid); end
    deq_ready = 2'b11; #1;
    nCompared++; if (req_ready !== 2'b00) begin nMismatch++; $display("FAIL credit_pop_cycle: got %b expected 00", req_ready); end
    tick(); deq_ready = 2'b01; #1;
    nCompared++; if (req_ready !== 2'b10) begin nMismatch++; $display("FAIL credit_returned: got %b expected 10", req_ready); end
    tick(); #1;
    nCompared++; if (req_ready !== 2'b00) begin nMismatch++; $display("FAIL credit_reexhausted: got %b expected 00", req_ready); end
  endtask

  task automatic test_vrf_stall();
    applyReset();
    req_valid = 2'b11; req_vs = {5'd21, 5'd10};
    #1; tick();
    vrf_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      nCompared++; if (req_ready !== 2'b00 || vrf_req_valid !== 1'b1 || vrf_req_vs !== 5'd21) begin
        nMismatch++; $display("FAIL stall_hold[%0d]: got %b/%b/%0d expected 00/1/21", i, req_ready, vrf_req_valid, vrf_req_vs); end
      tick();
    end
    vrf_req_ready = 1'b1; #1;
    nCompared++; if (req_ready !== 2'b10) begin nMismatch++; $display("FAIL stall_release: got %b expected 10", req_ready); end
    tick();
  endtask

  task automatic test_pop_and_fire();
    applyReset();
    deq_ready = 2'b00; req_valid = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    #1;
    nCompared++; if (deq_valid !== 2'b01) begin nMismatch++; $display("FAIL popfire_queued: got %b expected 01", deq_valid); end
    req_valid = 2'b01; deq_ready = 2'b01; #1;
    nCompared++; if (req_ready !== 2'b01) begin nMismatch++; $display("FAIL popfire_same_cycle: got %b expected 01", req_ready); end
    tick(); deq_ready = 2'b00; #1;
    nCompared++; if (req_ready !== 2'b01) begin nMismatch++; $display("FAIL popfire_one_left: got %b expected 01", req_ready); end
    tick(); #1;
    nCompared++; if (req_ready !== 2'b00) begin nMismatch++; $display("FAIL popfire_full: got %b expected 00", req_ready); end
  endtask

  task automatic test_reset_inflight();
    logic [DW-1:0] d;
    applyReset();
    deq_ready = 2'b00; req_valid = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    req_valid = 2'b10;
    tick(); tick();
    #1; rst_n = 1'b0; modelClear(); #1;
    nCompared++; if (deq_valid !== 2'b00) begin nMismatch++; $display("FAIL rst_flight_deq: got %b expected 00", deq_valid); end
    nCompared++; if (vrf_req_valid !== 1'b0 || req_ready !== 2'b00) begin nMismatch++; $display("FAIL rst_flight_req: got %b/%b expected 0/00", vrf_req_valid, req_ready); end
    tick();
    rst_n = 1'b1; req_valid = 2'b00; deq_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      nCompared++; if (deq_valid !== 2'b00) begin nMismatch++; $display("FAIL rst_flight_dropped[%0d]: got %b expected 00", i, deq_valid); end
      tick();
    end
    req_valid = 2'b10; #1;
    nCompared++; if (req_ready !== 2'b10) begin nMismatch++; $display("FAIL rst_flight_new_grant: got %b expected 10", req_ready); end
    tick(); req_valid = 2'b00; tick();
    d = 32'h5A5A_1234; vrf_rdata = d; tick(); #1;
    nCompared++; if (deq_valid !== 2'b10 || deq_data[2*DW-1:DW] !== d) begin
      nMismatch++; $display("FAIL rst_flight_own_data: got %b/%h expected 10/%h", deq_valid, deq_data[2*DW-1:DW], d); end
    tick(); #1;
    nCompared++; if (deq_valid !== 2'b00) begin nMismatch++; $display("FAIL rst_flight_only_one: got %b expected 00", deq_valid); end
  endtask

  task automatic test_random();
    int g;
    logic [NCH-1:0] e;
    applyReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid     = NCH'($urandom());
      deq_ready     = NCH'($urandom());
      vrf_req_ready = ($urandom_range(0, 3) != 0);
      req_vs        = (NCH*VSW)'($urandom());
      req_offset    = (NCH*OFW)'($urandom());
      req_source    = (NCH*SRW)'($urandom());
      req_index     = (NCH*IXW)'($urandom());
      #1;
      g = expGrant();
      e = '0;
      if (g >= 0 && vrf_req_ready) e[g] = 1'b1;
      nCompared++; if (vrf_req_valid !== (g >= 0)) begin nMismatch++; $display("FAIL rand_vrf_valid[%0d]: got %b expected %b", cyc, vrf_req_valid, g >= 0); end
      nCompared++; if (req_ready !== e) begin nMismatch++; $display("FAIL rand_req_ready[%0d]: got %b expected %b", cyc, req_ready, e); end
      if (g >= 0) begin
        nCompared++;
        if ({vrf_req_vs, vrf_req_offset, vrf_req_source, vrf_req_index} !==
            {req_vs[g*VSW +: VSW], req_offset[g*OFW +: OFW], req_source[g*SRW +: SRW], req_index[g*IXW +: IXW]}) begin
          nMismatch++; $display("FAIL rand_fields[%0d]: got %h/%h/%h/%h for channel %0d", cyc, vrf_req_vs, vrf_req_offset, vrf_req_source, vrf_req_index, g);
        end
      end
      for (int c = 0; c < NCH; c++) begin
        nCompared++; if (deq_valid[c] !== (expQ[c].size() > 0)) begin nMismatch++; $display("FAIL rand_deq_valid[%0d] ch%0d: got %b expected %b", cyc, c, deq_valid[c], expQ[c].size() > 0); end
        if (expQ[c].size() > 0) begin
          nCompared++; if (deq_data[c*DW +: DW] !== expQ[c][0]) begin nMismatch++; $display("FAIL rand_deq_data[%0d] ch%0d: got %h expected %h", cyc, c, deq_data[c*DW +: DW], expQ[c][0]); end
        end
      end
      tick();
    end
  endtask

  initial begin
    setIdle();
    vrf_rdata = '0;
    modelClear();
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_credit_backpressure();
    test_vrf_stall();
    test_pop_and_fire();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
`default_nettype wire
